btn_debounce_repeat: RTL and testbench

Conditions one raw push-button for the 7-segment clock's time-adjust path. The block synchronizes the asynchronous button, debounces it, and emits a single-cycle `pulse` per press, plus auto-repeat pulses while the button is held. It sits directly upstream of `hhmm_clock`, whose `dec` input consumes `pulse`, so one press steps the displayed time exactly once and a held press scrolls it.

---
 rtl/btn_debounce_repeat.sv | 167 ++++++++++++++++
 tb/tb_btn_debounce_repeat.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/btn_debounce_repeat.sv
// Push-button conditioner: 2-flop synchronizer, debouncer, press pulse and optional auto-repeat.
// Define BTN_AUTO_REPEAT_EN to build the hold/repeat behaviour; otherwise one pulse per press.
module btn_debounce_repeat #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn_raw,
  output logic o_pulse,
  output logic o_pressed,
  output logic o_held
);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("btn_debounce_repeat: cycle parameters must be >= 2");
  end

  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned     RP_MAX    = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned     RP_W      = $clog2(RP_MAX + 1);
  localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYCLES - 1);
  localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_HOLD, S_REPEAT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT_HOLD} state_t;
`endif

  logic            r_sync1;
  logic            r_sync2;
  logic [DB_W-1:0] r_db_cnt;
  logic [DB_W-1:0] w_db_cnt_next;
  logic            r_pressed;
  logic            w_db_toggle;
  logic            w_pressed_next;
  logic            r_pulse;
  logic            w_pulse_next;
  state_t          r_state;
  state_t          w_state_next;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw ^ BTN_ACTIVE_LOW;
      r_sync2 <= r_sync1;
    end
  end

  // Any cycle where sync agrees with the accepted level restarts the stability count.
  assign w_db_toggle    = (r_sync2 != r_pressed) && (r_db_cnt == DB_LAST);
  assign w_pressed_next = r_pressed ^ w_db_toggle;

  always_comb begin
    w_db_cnt_next = r_db_cnt + DB_W'(1);
    if (r_sync2 == r_pressed || w_db_toggle) begin
      w_db_cnt_next = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_db_cnt  <= '0;
      r_pressed <= 1'b0;
    end else begin
      r_db_cnt  <= w_db_cnt_next;
      r_pressed <= w_pressed_next;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  logic [RP_W-1:0] r_rp_cnt;
  logic [RP_W-1:0] w_rp_cnt_next;
  logic            r_held;
`endif

  // The FSM follows the next debounced level so pulse/held move in step with pressed;
  // release is tested first so it beats a coincident terminal count.
  always_comb begin
    w_state_next  = r_state;
    w_pulse_next  = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    w_rp_cnt_next = r_rp_cnt;
`endif
    if (!w_pressed_next) begin
      w_state_next  = S_IDLE;
`ifdef BTN_AUTO_REPEAT_EN
      w_rp_cnt_next = '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_pressed) begin
            w_state_next  = S_WAIT_HOLD;
            w_pulse_next  = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            w_rp_cnt_next = '0;
`endif
          end
        end
`ifdef BTN_AUTO_REPEAT_EN
        S_WAIT_HOLD: begin
          if (r_rp_cnt == HOLD_LAST) begin
            w_state_next  = S_REPEAT;
            w_pulse_next  = 1'b1;
            w_rp_cnt_next = '0;
          end else begin
            w_rp_cnt_next = r_rp_cnt + RP_W'(1);
          end
        end
        S_REPEAT: begin
          if (r_rp_cnt == REP_LAST) begin
            w_pulse_next  = 1'b1;
            w_rp_cnt_next = '0;
          end else begin
            w_rp_cnt_next = r_rp_cnt + RP_W'(1);
          end
        end
`else
        S_WAIT_HOLD: begin
          w_state_next = S_WAIT_HOLD;
        end
`endif
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pulse <= w_pulse_next;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rp_cnt <= '0;
      r_held   <= 1'b0;
    end else begin
      r_rp_cnt <= w_rp_cnt_next;
      r_held   <= (w_state_next == S_REPEAT);
    end
  end

  assign o_held = r_held;
`else
  assign o_held = 1'b0;
`endif

  assign o_pulse   = r_pulse;
  assign o_pressed = r_pressed;

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Directed bench for btn_debounce_repeat (DEBOUNCE=4, HOLD=20, REPEAT=8, active-high button).
// Expectations follow BTN_AUTO_REPEAT_EN, so the same bench covers both builds.
module tb_btn_debounce_repeat;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic btn_raw = 1'b0;
  logic pulse;
  logic pressed;
  logic held;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

`ifdef BTN_AUTO_REPEAT_EN
  localparam bit REP_BUILD = 1'b1;
`else
  localparam bit REP_BUILD = 1'b0;
`endif

  // Hand-derived pulse cycles for a press at cycle 0 held until release at cycle 68.
  int rep_pulses [7] = '{6, 26, 34, 42, 50, 58, 66};

  btn_debounce_repeat #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8),
    .BTN_ACTIVE_LOW (1'b0)
  ) u_dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_btn_raw (btn_raw),
    .o_pulse   (pulse),
    .o_pressed (pressed),
    .o_held    (held)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_outs(input string tag, input logic e_pulse, input logic e_pressed,
                            input logic e_held);
    check_eq({tag, ".pulse"},   pulse,   e_pulse);
    check_eq({tag, ".pressed"}, pressed, e_pressed);
    check_eq({tag, ".held"},    held,    e_held);
  endtask

  function automatic logic long_pulse(input int c);
    logic r;
    r = 1'b0;
    if (REP_BUILD) begin
      foreach (rep_pulses[i]) if (rep_pulses[i] == c) r = 1'b1;
    end else begin
      r = (c == 6);
    end
    return r;
  endfunction

  // Assert reset between edges, check asynchronous clear, hold, then release aligned to cycle 0.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_outs({tag, ".async"}, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check_outs({tag, ".held_in_rst"}, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic run_long_press(input string tag, input int last_cyc);
    while (cyc < last_cyc) begin
      btn_raw = (cyc < 68);
      step();
      check_outs(tag, long_pulse(cyc), (cyc >= 6 && cyc <= 73),
                 REP_BUILD && (cyc >= 26 && cyc <= 73));
    end
  endtask

  initial begin
    // Scenario 1: button high through reset, accepted once debounced after release.
    btn_raw = 1'b1;
    reset_n = 1'b0;
    #1;
    repeat (3) step();
    check_outs("s1.rst", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cyc = 0;
    while (cyc < 10) begin
      step();
      check_outs("s1", cyc == 6, cyc >= 6, 1'b0);
    end
    $display("scenario 1 reset-with-button-high done checks=%0d failures=%0d", checks, failures);

    btn_raw = 1'b0;
    do_reset("s2.rst");
    // Scenario 2: clean press held 12 cycles, released at cycle 12.
    while (cyc < 24) begin
      btn_raw = (cyc < 12);
      step();
      check_outs("s2", cyc == 6, (cyc >= 6 && cyc <= 17), 1'b0);
    end
    $display("scenario 2 clean press done checks=%0d failures=%0d", checks, failures);

    do_reset("s3.rst");
    // Scenario 3: toggles every 2 cycles for 12 cycles, stable high from cycle 12.
    while (cyc < 30) begin
      btn_raw = (cyc >= 12) ? 1'b1 : ((cyc / 2) % 2 == 0);
      step();
      check_outs("s3", cyc == 18, cyc >= 18, 1'b0);
    end
    $display("scenario 3 bouncing press done checks=%0d failures=%0d", checks, failures);

    btn_raw = 1'b0;
    do_reset("s4.rst");
    // Scenario 4: long hold; release at 68 drops pressed at 74, coinciding with a repeat terminal count.
    run_long_press("s4", 90);
    $display("scenario 4 long hold done checks=%0d failures=%0d", checks, failures);

    btn_raw = 1'b0;
    do_reset("s5.pre");
    // Scenario 5: long hold interrupted by reset at cycle 40, button still held.
    run_long_press("s5", 40);
    check_eq("s5.held_before_rst", held, REP_BUILD);
    check_eq("s5.pressed_before_rst", pressed, 1'b1);
    do_reset("s5.mid");
    while (cyc < 12) begin
      btn_raw = 1'b1;
      step();
      check_outs("s5.after", cyc == 6, cyc >= 6, 1'b0);
    end
    $display("scenario 5 reset mid-repeat done checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
